instruction_fetch_queue: RTL and testbench
==========================================

Name: instruction_fetch_queue

Overview:
- Small FIFO between the instruction fetch stage and the decode stage.
- Captures each {instruction, nextPC} pair that the fetch stage produces while instruction memory reports ready.
- Presents the oldest pair to decode, and absorbs decode stalls without losing fetched words.
- Back-pressures fetch through oFetchStall, and discards all contents on a redirect flush (jump, branch, branch miss, return).

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- NOP_WORD, 32'h00000000, instruction driven to decode when the queue is empty.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iReset  input  1  synchronous, active-high reset.
- iInstruction  input  32  fetched instruction word from the fetch stage.
- iNextPC  input  32  PC+1 of the fetched word, from the fetch stage.
- iMemReady  input  1  fetch word is valid this cycle (push request).
- iFlush  input  1  redirect; drop all entries and any same-cycle push.
- iDecodeStall  input  1  decode cannot accept the head entry this cycle.
- oInstruction  output  32  head entry instruction, or NOP_WORD when empty.
- oNextPC  output  32  head entry nextPC, or 0 when empty.
- oValid  output  1  head entry is valid.
- oFetchStall  output  1  queue full; fetch must hold its PC.
- oCount  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array {instruction, nextPC}, a write pointer, a read pointer and a count register. Pointers wrap modulo DEPTH.
- push = iMemReady & ~full & ~iFlush.
- pop = oValid & ~iDecodeStall & ~iFlush.
- full = (count == DEPTH); empty = (count == 0).
- Reset, when iReset=1 at a clock edge:
  - wptr=0, rptr=0, count=0.
  - Outputs become oValid=0, oInstruction=NOP_WORD, oNextPC=0, oFetchStall=0, oCount=0.
  - Reset has priority over flush, push and pop. Array contents are don't-care after reset.
- Flush (iFlush=1, not in reset):
  - Next cycle wptr=rptr=0, count=0.
  - A same-cycle push is discarded and the head is not popped.
  - Decode must treat a head presented during the flush cycle as killed.
- Normal update:
  - push only: write at wptr, wptr+1, count+1.
  - pop only: rptr+1, count-1.
  - push and pop together: both pointers advance and count is unchanged. Legal at any occupancy 1..DEPTH-1.
  - When full, push is blocked even if a pop happens in the same cycle; the fetch stage re-presents the word.
  - neither: hold.
- Latency:
  - A word pushed at edge N is visible at the head at edge N+1.
  - There is no combinational bypass from iInstruction to oInstruction.
- Outputs:
  - oValid = ~empty.
  - oInstruction and oNextPC come combinationally from array[rptr] when valid; otherwise NOP_WORD and 0.
  - oFetchStall = full, a registered-state decode only (no dependency on the iDecodeStall input).
  - oCount = count.
- iMemReady while full: the word is dropped here by design. The fetch stage holds the PC under oFetchStall, so the word is not lost.
- Pop while empty: impossible by construction (oValid=0), so no pointer movement.
- count never exceeds DEPTH and never underflows; the bench asserts this every cycle.

Decomposition:
- Shared package holds:
  - NOP_WORD.
  - Instruction/PC width constants (32).
  - A packed entry typedef {instr[31:0], next_pc[31:0]}, so decode and fetch use the same layout.
- One natural sub-module, fetch_queue_mem: a DEPTH x 64 register array with one write port and one asynchronous read port.
- The pointer/count control stays in the top module.

Test Plan:
- Reset then idle -> oValid=0, oInstruction=32'h00000000, oCount=0, oFetchStall=0.
- Push 0xAAAA0001/PC 1, 0xAAAA0002/PC 2 with iDecodeStall=1:
  - count=2.
  - Head shows 0xAAAA0001/1 from the cycle after the first push.
  - Release the stall -> pops in order 0x..01 then 0x..02, then oValid=0.
- Fill to 4 with iDecodeStall=1 -> oFetchStall=1, oCount=4. A fifth push of 0xBBBB0005 is ignored. Pop one -> oFetchStall=0 the next cycle.
- Simultaneous push and pop at count=2 over 8 cycles -> count stays 2, data emerges in FIFO order, and pointers wrap past 3 to 0 correctly.
- iFlush with count=3 and iMemReady=1 in the same cycle -> next cycle count=0, oValid=0, and the flushed-cycle word is absent.
- iReset asserted mid-stream with count=3 and iFlush=1 -> all outputs return to reset values next cycle. The first push after reset appears at the head with count=1.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the fetch->decode queue: word widths, the idle
// instruction and the packed {instr, next_pc} entry layout.
package instruction_fetch_queue_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;

   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    next_pc;
   } fq_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch/decode-side signal bundle of the instruction fetch queue; the queue
// itself connects through the slave modport.
interface instruction_fetch_queue_if
   import instruction_fetch_queue_pkg::*;
   #(parameter int unsigned PTR_W = 2);

   logic [INSTR_W-1:0] iInstruction;
   logic [PC_W-1:0]    iNextPC;
   logic               iMemReady;
   logic               iFlush;
   logic               iDecodeStall;
   logic [INSTR_W-1:0] oInstruction;
   logic [PC_W-1:0]    oNextPC;
   logic               oValid;
   logic               oFetchStall;
   logic [PTR_W:0]     oCount;

   modport master (
      output iInstruction, iNextPC, iMemReady, iFlush, iDecodeStall,
      input  oInstruction, oNextPC, oValid, oFetchStall, oCount
   );

   modport slave (
      input  iInstruction, iNextPC, iMemReady, iFlush, iDecodeStall,
      output oInstruction, oNextPC, oValid, oFetchStall, oCount
   );

endinterface

// File: rtl/instruction_fetch_queue_mem.sv
// DEPTH x entry register array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module instruction_fetch_queue_mem
   import instruction_fetch_queue_pkg::*;
   #(
      parameter int unsigned DEPTH = 4,
      parameter int unsigned PTR_W = $clog2(DEPTH)
   )
   (
      input  logic             clk,
      input  logic             we,
      input  logic [PTR_W-1:0] waddr,
      input  fq_entry_t        wdata,
      input  logic [PTR_W-1:0] raddr,
      output fq_entry_t        rdata
   );

   fq_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// FIFO between fetch and decode: captures {instruction, nextPC} while memory is
// ready, presents the oldest entry, back-pressures fetch when full.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
   #(
      parameter int unsigned        DEPTH    = 4,
      parameter int unsigned        PTR_W    = $clog2(DEPTH),
      parameter logic [INSTR_W-1:0] NOP_WORD = instruction_fetch_queue_pkg::NOP_WORD
   )
   (
      input logic                       iClk,
      input logic                       iReset,
      instruction_fetch_queue_if.slave  q
   );

   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   fq_entry_t        wr_entry;
   fq_entry_t        head;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   // Full blocks push even when a pop happens in the same cycle; fetch re-presents.
   assign push  = q.iMemReady & ~full & ~q.iFlush;
   assign pop   = ~empty & ~q.iDecodeStall & ~q.iFlush;

   assign wr_entry.instr   = q.iInstruction;
   assign wr_entry.next_pc = q.iNextPC;

   instruction_fetch_queue_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (iClk),
      .we    (push & ~iReset),
      .waddr (wptr),
      .wdata (wr_entry),
      .raddr (rptr),
      .rdata (head)
   );

   always_ff @(posedge iClk) begin
      if (iReset || q.iFlush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop) begin
            rptr <= rptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign q.oValid       = ~empty;
   assign q.oInstruction = empty ? NOP_WORD : head.instr;
   assign q.oNextPC      = empty ? '0 : head.next_pc;
   assign q.oFetchStall  = full;
   assign q.oCount       = count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_instruction_fetch_queue;
   import instruction_fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst;

   instruction_fetch_queue_if #(.PTR_W(2)) bus ();

   instruction_fetch_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .iClk   (clk),
      .iReset (rst),
      .q      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec;
   int unsigned n_bad;
   bit          model_known;
   logic [63:0] model_q[$];

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_vec++;
      if (observed !== expected) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic compare_outputs();
      logic [63:0] head;
      int unsigned sz;
      sz   = model_q.size();
      head = (sz > 0) ? model_q[0] : {NOP_WORD, 32'h0};
      check("valid", 64'(bus.oValid), 64'(sz > 0));
      check("count", 64'(bus.oCount), 64'(sz));
      check("fetch_stall", 64'(bus.oFetchStall), 64'(sz == DEPTH));
      check("instr", 64'(bus.oInstruction), 64'(head[63:32]));
      check("next_pc", 64'(bus.oNextPC), 64'(head[31:0]));
      check("count_bound", 64'(bus.oCount <= 3'(DEPTH)), 64'd1);
   endtask

   // One clock: drive inputs, check state-derived outputs mid-cycle, advance model.
   task automatic cycle(input logic r, input logic rdy, input logic fl, input logic st,
                        input logic [31:0] ins, input logic [31:0] pc);
      rst              = r;
      bus.iMemReady    = rdy;
      bus.iFlush       = fl;
      bus.iDecodeStall = st;
      bus.iInstruction = ins;
      bus.iNextPC      = pc;
      #4;
      if (model_known) compare_outputs();
      if (r || fl) begin
         model_q.delete();
      end else begin
         bit do_push;
         do_push = rdy && (model_q.size() < DEPTH);
         if (model_q.size() > 0 && !st) void'(model_q.pop_front());
         if (do_push) model_q.push_back({ins, pc});
      end
      if (r) model_known = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic st, input int unsigned n);
      for (int i = 0; i < int'(n); i++) cycle(0, 0, 0, st, 32'hDEAD_BEEF, 32'h0);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      model_known = 1'b0;
      rst = 1'b1;
      bus.iMemReady = 0; bus.iFlush = 0; bus.iDecodeStall = 0;
      bus.iInstruction = '0; bus.iNextPC = '0;
      #1;

      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      idle(0, 2);

      // two pushes under decode stall, then drain in order
      cycle(0, 1, 0, 1, 32'hAAAA_0001, 32'd1);
      cycle(0, 1, 0, 1, 32'hAAAA_0002, 32'd2);
      idle(1, 1);
      idle(0, 3);

      // fill, attempted fifth push, then one pop
      for (int i = 1; i <= 4; i++) cycle(0, 1, 0, 1, 32'hBBBB_0000 + 32'(i), 32'(i));
      cycle(0, 1, 0, 1, 32'hBBBB_0005, 32'd5);
      cycle(0, 1, 0, 0, 32'hBBBB_0005, 32'd5);
      idle(1, 2);
      idle(0, 4);

      // steady push+pop at occupancy 2, wrapping pointers
      cycle(0, 1, 0, 1, 32'hC000_0001, 32'd11);
      cycle(0, 1, 0, 1, 32'hC000_0002, 32'd12);
      for (int i = 3; i <= 10; i++) cycle(0, 1, 0, 0, 32'hC000_0000 + 32'(i), 32'(10 + i));
      idle(0, 3);

      // flush with a same-cycle push at occupancy 3
      for (int i = 1; i <= 3; i++) cycle(0, 1, 0, 1, 32'hD000_0000 + 32'(i), 32'(20 + i));
      cycle(0, 1, 1, 1, 32'hD000_00FF, 32'd99);
      idle(1, 2);

      // reset beats flush and push mid-stream
      for (int i = 1; i <= 3; i++) cycle(0, 1, 0, 1, 32'hE000_0000 + 32'(i), 32'(30 + i));
      cycle(1, 1, 1, 1, 32'hE000_00FF, 32'd98);
      cycle(0, 1, 0, 1, 32'hF000_0001, 32'd41);
      idle(1, 1);
      idle(0, 2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 9) < 4),
               $urandom, $urandom);
      end
      idle(0, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
